// File: rtl/seq_alu_mul_if.sv
// Request/response bundle for seq_alu_mul.
//   master: drives start, op, a, b; observes busy, done, result, ovf
//   slave : the ALU side
interface seq_alu_mul_if #(
  parameter int unsigned NBITS = 4
) ();
  logic                 start;
  logic [1:0]           op;
  logic [NBITS-1:0]     a;
  logic [NBITS-1:0]     b;
  logic                 busy;
  logic                 done;
  logic [2*NBITS-1:0]   result;
  logic                 ovf;

  modport master (
    output start, op, a, b,
    input  busy, done, result, ovf
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, result, ovf
  );
endinterface

// File: rtl/seq_alu_mul.sv
// Sequential ALU: single-cycle signed add/sub, NBITS-cycle shift-add multiplier
// (unsigned, or signed via magnitudes and a final negate).
// Ports:
//   clk_2   - clock, rising edge
//   reset   - asynchronous active-high reset
//   alu_io  - seq_alu_mul_if.slave: start/op/a/b in, busy/done/result/ovf out
// Optional feature: define SEQ_ALU_SATURATE_EN to saturate add/sub overflow
// instead of returning zero.
module seq_alu_mul #(
  parameter int unsigned NBITS = 4
) (
  input logic           clk_2,
  input logic           reset,
  seq_alu_mul_if.slave  alu_io
);

  localparam int unsigned CntW = $clog2(NBITS + 1);

  typedef enum logic [1:0] {StIdle, StMul, StDone} state_e;

  state_e               state_q, state_d;
  logic [2*NBITS-1:0]   mcand_q, mcand_d;   // multiplicand, shifted left each step
  logic [NBITS-1:0]     mplier_q, mplier_d; // multiplier, shifted right each step
  logic [2*NBITS-1:0]   acc_q, acc_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic                 neg_q, neg_d;       // signed mul: negate magnitude product
  logic [2*NBITS-1:0]   result_q, result_d;
  logic                 ovf_q, ovf_d;

  // Add/sub at NBITS+1 bits; modular arithmetic matches the signed true value.
  logic [NBITS:0]       a_ext, b_ext, sum;
  logic                 as_ovf;
  logic [2*NBITS-1:0]   as_result;

  logic [NBITS-1:0]     a_mag, b_mag;
  logic                 mul_neg;
  logic [2*NBITS-1:0]   acc_step;
  logic                 last_iter;

  always_comb begin
    a_ext  = {alu_io.a[NBITS-1], alu_io.a};
    b_ext  = {alu_io.b[NBITS-1], alu_io.b};
    sum    = alu_io.op[0] ? (a_ext - b_ext) : (a_ext + b_ext);
    as_ovf = sum[NBITS] ^ sum[NBITS-1];
    if (!as_ovf) begin
      as_result = {{(NBITS-1){sum[NBITS]}}, sum};
    end else begin
`ifdef SEQ_ALU_SATURATE_EN
      // sum[NBITS] holds the true sign: 0 means positive overflow.
      as_result = sum[NBITS] ? {{(NBITS+1){1'b1}}, {(NBITS-1){1'b0}}}
                             : {{(NBITS+1){1'b0}}, {(NBITS-1){1'b1}}};
`else
      as_result = '0;
`endif
    end
  end

  // Magnitudes are NBITS-bit unsigned, so -2^(NBITS-1) maps to 2^(NBITS-1) exactly.
  always_comb begin
    a_mag   = (alu_io.op[0] && alu_io.a[NBITS-1]) ? -alu_io.a : alu_io.a;
    b_mag   = (alu_io.op[0] && alu_io.b[NBITS-1]) ? -alu_io.b : alu_io.b;
    mul_neg = alu_io.op[0] & (alu_io.a[NBITS-1] ^ alu_io.b[NBITS-1]);
  end

  always_comb begin
    acc_step  = acc_q + (mplier_q[0] ? mcand_q : '0);
    last_iter = (cnt_q == CntW'(NBITS - 1));
  end

  // State register
  always_ff @(posedge clk_2 or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (alu_io.start) begin
          state_d = alu_io.op[1] ? StMul : StDone;
        end
      end
      StMul: begin
        if (last_iter) begin
          state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Datapath next-state
  always_comb begin
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    neg_d    = neg_q;
    result_d = result_q;
    ovf_d    = ovf_q;
    unique case (state_q)
      StIdle: begin
        if (alu_io.start) begin
          if (alu_io.op[1]) begin
            mcand_d  = {{NBITS{1'b0}}, a_mag};
            mplier_d = b_mag;
            acc_d    = '0;
            cnt_d    = '0;
            neg_d    = mul_neg;
          end else begin
            result_d = as_result;
            ovf_d    = as_ovf;
          end
        end
      end
      StMul: begin
        acc_d    = acc_step;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CntW'(1);
        if (last_iter) begin
          result_d = neg_q ? -acc_step : acc_step;
          ovf_d    = 1'b0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_2 or posedge reset) begin
    if (reset) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
      result_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      neg_q    <= neg_d;
      result_q <= result_d;
      ovf_q    <= ovf_d;
    end
  end

  // Outputs
  always_comb begin
    alu_io.busy   = (state_q != StIdle);
    alu_io.done   = (state_q == StDone);
    alu_io.result = result_q;
    alu_io.ovf    = ovf_q;
  end

endmodule

// File: tb/tb_seq_alu_mul.sv
module tb_seq_alu_mul;
  localparam int unsigned N = 4;

  logic clk_2 = 1'b0;
  logic reset;
  int   n_tests = 0;
  int   n_fail  = 0;

  seq_alu_mul_if #(.NBITS(N)) bus ();

  seq_alu_mul #(.NBITS(N)) dut (
    .clk_2  (clk_2),
    .reset  (reset),
    .alu_io (bus)
  );

  always #5 clk_2 = ~clk_2;

  // Reference: the arithmetic result straight from the operation definitions.
  function automatic logic [2*N:0] model(input logic [1:0] op, input logic [N-1:0] a,
                                         input logic [N-1:0] b);
    int sa, sb, ua, ub, v, lo, hi;
    logic ov;
    sa = $signed(a);
    sb = $signed(b);
    ua = int'(a);
    ub = int'(b);
    lo = -(1 << (N - 1));
    hi = (1 << (N - 1)) - 1;
    ov = 1'b0;
    case (op)
      2'd0:    v = sa + sb;
      2'd1:    v = sa - sb;
      2'd2:    v = ua * ub;
      default: v = sa * sb;
    endcase
    if (op < 2'd2 && (v > hi || v < lo)) begin
      ov = 1'b1;
`ifdef SEQ_ALU_SATURATE_EN
      v = (v > hi) ? hi : lo;
`else
      v = 0;
`endif
    end
    return {ov, v[2*N-1:0]};
  endfunction

  // Issue one request from a negedge in IDLE; returns what was observed.
  // With scramble set, start stays high with op=0 and fresh operands until done.
  task automatic do_op(input logic [1:0] op, input logic [N-1:0] a, input logic [N-1:0] b,
                       input bit scramble, output int lat, output int busy_cnt,
                       output logic [2*N-1:0] res, output logic ov, output logic done_after,
                       output logic busy_after, output logic [2*N-1:0] res_after);
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    lat       = 0;
    busy_cnt  = 0;
    do begin
      @(negedge clk_2);
      lat++;
      if (bus.busy) busy_cnt++;
      if (scramble && !bus.done) begin
        bus.start = 1'b1;
        bus.op    = 2'd0;
        bus.a     = N'($urandom);
        bus.b     = N'($urandom);
      end else begin
        bus.start = 1'b0;
      end
    end while (!bus.done && lat < 40);
    bus.start  = 1'b0;
    res        = bus.result;
    ov         = bus.ovf;
    @(negedge clk_2);
    done_after = bus.done;
    busy_after = bus.busy;
    res_after  = bus.result;
  endtask

  task automatic test_reset;
    int lat, bc;
    logic [2*N-1:0] res, res2;
    logic ov, da, ba;
    reset     = 1'b1;
    bus.start = 1'b0;
    bus.op    = 2'd0;
    bus.a     = '0;
    bus.b     = '0;
    repeat (2) @(negedge clk_2);
    n_tests++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.result !== '0 || bus.ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: busy=%b done=%b result=%h ovf=%b, want 0 0 00 0",
               bus.busy, bus.done, bus.result, bus.ovf);
    end
    reset = 1'b0;
    // First start on the first edge after release.
    do_op(2'd0, 4'd3, 4'hE, 1'b0, lat, bc, res, ov, da, ba, res2);
    n_tests++;
    if (lat !== 1 || res !== 8'h01 || ov !== 1'b0) begin
      n_fail++;
      $display("FAIL first_start: lat=%0d result=%h ovf=%b, want 1 01 0", lat, res, ov);
    end
  endtask

  task automatic test_directed;
    logic [1:0]     ops [8] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    logic [N-1:0]   as  [8] = '{4'd3, 4'd5, 4'h8, 4'h8, 4'hF, 4'hD, 4'h8, 4'h0};
    logic [N-1:0]   bs  [8] = '{4'hE, 4'd4, 4'd1, 4'hF, 4'hF, 4'd5, 4'h8, 4'h8};
`ifdef SEQ_ALU_SATURATE_EN
    logic [2*N-1:0] ers [8] = '{8'h01, 8'h07, 8'hF8, 8'hF9, 8'hE1, 8'hF1, 8'h40, 8'h00};
`else
    logic [2*N-1:0] ers [8] = '{8'h01, 8'h00, 8'h00, 8'hF9, 8'hE1, 8'hF1, 8'h40, 8'h00};
`endif
    logic           eos [8] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    int lat, bc, elat;
    logic [2*N-1:0] res, res2;
    logic ov, da, ba;
    for (int i = 0; i < 8; i++) begin
      do_op(ops[i], as[i], bs[i], 1'b0, lat, bc, res, ov, da, ba, res2);
      elat = ops[i][1] ? N + 1 : 1;
      n_tests++;
      if (res !== ers[i] || ov !== eos[i]) begin
        n_fail++;
        $display("FAIL directed_%0d: result=%h ovf=%b, want %h %b", i, res, ov, ers[i], eos[i]);
      end
      n_tests++;
      if (lat !== elat || bc !== elat || da !== 1'b0 || ba !== 1'b0) begin
        n_fail++;
        $display("FAIL directed_timing_%0d: lat=%0d busy=%0d done_after=%b busy_after=%b, want %0d %0d 0 0",
                 i, lat, bc, da, ba, elat, elat);
      end
    end
  endtask

  task automatic test_random(input bit mul);
    int lat, bc, elat, bad;
    logic [1:0] op;
    logic [N-1:0] a, b;
    logic [2*N:0] exp;
    logic [2*N-1:0] res, res2;
    logic ov, da, ba;
    bad = 0;
    for (int i = 0; i < 60; i++) begin
      op = {mul, 1'($urandom)};
      a  = N'($urandom);
      b  = N'($urandom);
      exp = model(op, a, b);
      elat = mul ? N + 1 : 1;
      do_op(op, a, b, 1'b0, lat, bc, res, ov, da, ba, res2);
      n_tests++;
      if (res !== exp[2*N-1:0] || ov !== exp[2*N] || lat !== elat || res2 !== res || da !== 1'b0) begin
        n_fail++;
        $display("FAIL random_%s op=%0d a=%h b=%h: result=%h ovf=%b lat=%0d hold=%h, want %h %b %0d",
                 mul ? "mul" : "addsub", op, a, b, res, ov, lat, res2, exp[2*N-1:0], exp[2*N], elat);
      end
    end
  endtask

  task automatic test_back_to_back;
    int lat, bc;
    logic [2*N-1:0] res, res2;
    logic ov, da, ba;
    logic [2*N:0] exp;
    for (int i = 0; i < 6; i++) begin
      logic [N-1:0] a, b;
      logic [1:0] op;
      a  = N'($urandom);
      b  = N'($urandom);
      op = {1'b1, 1'($urandom)};
      exp = model(op, a, b);
      do_op(op, a, b, 1'b1, lat, bc, res, ov, da, ba, res2);
      n_tests++;
      if (res !== exp[2*N-1:0] || ov !== exp[2*N] || lat !== N + 1) begin
        n_fail++;
        $display("FAIL b2b_result_%0d: result=%h ovf=%b lat=%0d, want %h %b %0d",
                 i, res, ov, lat, exp[2*N-1:0], exp[2*N], N + 1);
      end
      @(negedge clk_2);
      n_tests++;
      if (da !== 1'b0 || ba !== 1'b0 || bus.done !== 1'b0 || bus.busy !== 1'b0) begin
        n_fail++;
        $display("FAIL b2b_no_queue_%0d: done_after=%b busy_after=%b done=%b busy=%b, want 0 0 0 0",
                 i, da, ba, bus.done, bus.busy);
      end
    end
  endtask

  task automatic test_reset_mid_mul;
    int lat, bc, stray;
    logic [2*N-1:0] res, res2;
    logic ov, da, ba;
    do_op(2'd2, 4'd3, 4'd5, 1'b0, lat, bc, res, ov, da, ba, res2);
    bus.start = 1'b1;
    bus.op    = 2'd2;
    bus.a     = 4'd7;
    bus.b     = 4'd9;
    @(negedge clk_2);
    bus.start = 1'b0;
    @(negedge clk_2);
    reset = 1'b1;
    #1;
    n_tests++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.result !== '0 || bus.ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_mul: busy=%b done=%b result=%h ovf=%b, want 0 0 00 0",
               bus.busy, bus.done, bus.result, bus.ovf);
    end
    @(negedge clk_2);
    reset = 1'b0;
    stray = 0;
    for (int i = 0; i < N + 4; i++) begin
      @(negedge clk_2);
      if (bus.done !== 1'b0 || bus.busy !== 1'b0) stray++;
    end
    n_tests++;
    if (stray !== 0) begin
      n_fail++;
      $display("FAIL reset_abort: %0d cycles with done/busy after release, want 0", stray);
    end
    do_op(2'd3, 4'h8, 4'h8, 1'b0, lat, bc, res, ov, da, ba, res2);
    n_tests++;
    if (res !== 8'h40 || ov !== 1'b0 || lat !== N + 1) begin
      n_fail++;
      $display("FAIL post_reset_mul: result=%h ovf=%b lat=%0d, want 40 0 %0d", res, ov, lat, N + 1);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random(1'b0);
    test_random(1'b1);
    test_back_to_back();
    test_reset_mid_mul();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, want completion");
    $fatal(1);
  end

endmodule

// File: doc/seq_alu_mul.md
SEQ_ALU_MUL -- requirements
Module: seq_alu_mul

Interface
REQ-001 Parameter NBITS, default 4, operand width; legal range 2..16.
REQ-002 clk_2  input  1  system clock, all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  request; sampled only in IDLE.
REQ-005 op  input  2  operation: 0 signed add, 1 signed sub, 2 unsigned mul, 3 signed mul.
REQ-006 a  input  NBITS  operand A.
REQ-007 b  input  NBITS  operand B.
REQ-008 busy  output  1  high while a request is in progress (states MUL and DONE excluded from IDLE).
REQ-009 done  output  1  one-cycle pulse, result valid.
REQ-010 result  output  2*NBITS  registered result.
REQ-011 ovf  output  1  registered overflow flag for the last completed operation.

Function
REQ-012 FSM states IDLE, MUL, DONE; IDLE->DONE on start with op 0/1; IDLE->MUL on start with op 2/3; MUL->DONE after NBITS iteration cycles; DONE->IDLE unconditionally.
REQ-013 a, b, op SHALL be latched on the start cycle; later input changes SHALL not affect the operation.
REQ-014 start while not in IDLE SHALL be ignored, no queueing.
REQ-015 done SHALL assert exactly 1 cycle after the start edge for add/sub and exactly NBITS+1 cycles after for mul, for one cycle only.
REQ-016 result and ovf SHALL update only on the cycle done asserts and hold until the next done.
REQ-017 Add/sub: operands signed two's complement; true result computed at NBITS+1 bits; ovf=1 when outside [-2^(NBITS-1), 2^(NBITS-1)-1].
REQ-018 Add/sub without overflow: result = true value sign-extended to 2*NBITS.
REQ-019 Unsigned mul: shift-add, one partial product per cycle, result = a*b zero-extended, exact in 2*NBITS, ovf=0.
REQ-020 Signed mul: multiply magnitudes with REQ-019 datapath, negate at completion when operand signs differ; result exact in 2*NBITS two's complement, ovf=0; (-2^(NBITS-1))^2 SHALL be exact.
REQ-021 busy SHALL be 0 in IDLE, 1 in MUL and DONE.

Reset
REQ-022 reset SHALL immediately force IDLE, busy=0, done=0, result=0, ovf=0, clearing latched operands and accumulator.
REQ-023 reset asserted mid-MUL SHALL abort the operation with no done pulse after release.
REQ-024 First start SHALL be accepted on the first rising edge after reset deasserts.

Configuration
REQ-025 Macro SEQ_ALU_SATURATE_EN: when defined, add/sub overflow SHALL give result = 2^(NBITS-1)-1 on positive overflow or -2^(NBITS-1) on negative overflow, sign-extended, ovf=1.
REQ-026 When SEQ_ALU_SATURATE_EN is undefined, add/sub overflow SHALL give result=0, ovf=1; mul behaviour unaffected either way.

Verification (NBITS=4)
REQ-027 op=0, a=3, b=-2, start -> done next cycle, result=8'h01, ovf=0; a=5, b=4 -> ovf=1, result=8'h00 (8'h07 with SEQ_ALU_SATURATE_EN).
REQ-028 op=1, a=-8, b=1 -> ovf=1, result=8'h00 (8'hF8 with SEQ_ALU_SATURATE_EN); a=-8, b=-1 -> result=8'hF9, ovf=0.
REQ-029 op=2, a=15, b=15 -> busy for 5 cycles, done 5 cycles after start, result=8'hE1, ovf=0.
REQ-030 op=3, a=-3, b=5 -> result=8'hF1; a=-8, b=-8 -> result=8'h40; a=0, b=-8 -> result=8'h00.
REQ-031 op=2 start, second start with op=0 during MUL, and a/b changed after start -> only first operation completes with original operands, single done pulse.
REQ-032 Reset asserted 2 cycles into a mul -> busy=0, result=0 immediately, no done after release; new start then completes normally.
